tri_sweep_ctrl: RTL and testbench

Frequency-sweep sequencer for the triangle-wave generator's phase-step input. On a start request it latches a sweep profile, walks the generator step from a start value to a stop value in fixed increments, and holds each value for a programmable dwell time. It sits between the PS-side register file and the `step` input of the triangle generator, and reports busy/done back to software.

---
 rtl/tri_sweep_if.sv | 22 ++
 rtl/tri_sweep_ctrl.sv | 133 +++++++++++++
 tb/tb_tri_sweep_ctrl.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tri_sweep_if.sv
// tri_sweep_if: sweep request/config and status bundle between register file and tri_sweep_ctrl.
interface tri_sweep_if #(parameter int STEP_W = 32, parameter int DWELL_W = 24);
    logic               start;
    logic               abort;
    logic [STEP_W-1:0]  cfg_step_start;
    logic [STEP_W-1:0]  cfg_step_stop;
    logic [STEP_W-1:0]  cfg_step_inc;
    logic [DWELL_W-1:0] cfg_dwell;
    logic [STEP_W-1:0]  step_out;
    logic               step_valid;
    logic               busy;
    logic               done;
    logic               sweep_dir;
    modport master (
        output start, abort, cfg_step_start, cfg_step_stop, cfg_step_inc, cfg_dwell,
        input  step_out, step_valid, busy, done, sweep_dir
    );
    modport slave (
        input  start, abort, cfg_step_start, cfg_step_stop, cfg_step_inc, cfg_dwell,
        output step_out, step_valid, busy, done, sweep_dir
    );
endinterface

// File: rtl/tri_sweep_ctrl.sv
// tri_sweep_ctrl: dwell-timed step sweep for the triangle generator; TRI_SWEEP_BIDIR_EN adds a down-leg.
module tri_sweep_ctrl #(
    parameter int STEP_W  = 32,
    parameter int DWELL_W = 24
) (
    input  logic       clk,
    input  logic       rst_n,
    tri_sweep_if.slave io_sw
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        UP   = 2'd1,
`ifdef TRI_SWEEP_BIDIR_EN
        DOWN = 2'd2,
`endif
        FIN  = 2'd3
    } state_t;

    state_t             r_state, w_next;
    logic [STEP_W-1:0]  r_stop, r_inc, r_step, w_step, w_up;
    logic [DWELL_W-1:0] r_dwell, r_cnt, w_cnt;
    logic [STEP_W:0]    w_sum;
    logic               r_valid, w_valid, r_busy, r_done;
    logic               w_accept, w_abort, w_expire, w_up_end, w_run;
`ifdef TRI_SWEEP_BIDIR_EN
    logic [STEP_W-1:0]  r_start, w_dn;
    logic [STEP_W:0]    w_diff;
    logic               w_at_start, r_dir;
`endif

    assign w_accept = r_state == IDLE && io_sw.start && !io_sw.abort;
    assign w_abort  = r_state != IDLE && io_sw.abort;
    assign w_expire = r_cnt == '0;
    // carry out of the wide sum means the step would wrap, so clamp to stop
    assign w_sum    = {1'b0, r_step} + {1'b0, r_inc};
    assign w_up     = (w_sum[STEP_W] || w_sum[STEP_W-1:0] > r_stop) ? r_stop : w_sum[STEP_W-1:0];
    assign w_up_end = r_step >= r_stop || r_inc == '0;
`ifdef TRI_SWEEP_BIDIR_EN
    assign w_diff     = {1'b0, r_step} - {1'b0, r_inc};
    assign w_dn       = (w_diff[STEP_W] || w_diff[STEP_W-1:0] < r_start) ? r_start : w_diff[STEP_W-1:0];
    assign w_at_start = r_step <= r_start;
    assign w_run      = r_state == UP || r_state == DOWN;
`else
    assign w_run      = r_state == UP;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = IDLE;
        case (r_state)
            IDLE: w_next = w_accept ? UP : IDLE;
`ifdef TRI_SWEEP_BIDIR_EN
            // the stop stage's dwell is shared by both legs, so leave it stepping down
            UP:   w_next = (w_expire && w_up_end) ? (w_at_start ? FIN : DOWN) : UP;
            DOWN: w_next = (w_expire && w_at_start) ? FIN : DOWN;
`else
            UP:   w_next = (w_expire && w_up_end) ? FIN : UP;
`endif
            default: w_next = IDLE;
        endcase
        if (w_abort) w_next = IDLE;
    end

    always_comb begin
        w_step  = r_step;
        w_valid = 1'b0;
        w_cnt   = r_cnt;
        if (w_abort) begin
            w_step  = '0;
            w_valid = 1'b1;
        end else if (w_accept) begin
            w_step  = io_sw.cfg_step_start;
            w_valid = 1'b1;
            w_cnt   = io_sw.cfg_dwell;
        end else if (w_run && !w_expire) begin
            w_cnt = r_cnt - DWELL_W'(1);
        end else if (w_run && w_next != FIN) begin
`ifdef TRI_SWEEP_BIDIR_EN
            w_step  = w_next == UP ? w_up : w_dn;
`else
            w_step  = w_up;
`endif
            w_valid = 1'b1;
            w_cnt   = r_dwell;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_step  <= '0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_cnt   <= '0;
            r_stop  <= '0;
            r_inc   <= '0;
            r_dwell <= '0;
`ifdef TRI_SWEEP_BIDIR_EN
            r_start <= '0;
            r_dir   <= 1'b0;
`endif
        end else begin
            r_step  <= w_step;
            r_valid <= w_valid;
            r_cnt   <= w_cnt;
            r_busy  <= w_next != IDLE && w_next != FIN;
            r_done  <= w_next == FIN;
`ifdef TRI_SWEEP_BIDIR_EN
            r_dir   <= w_next == DOWN;
            if (w_accept) r_start <= io_sw.cfg_step_start;
`endif
            if (w_accept) begin
                r_stop  <= io_sw.cfg_step_stop;
                r_inc   <= io_sw.cfg_step_inc;
                r_dwell <= io_sw.cfg_dwell;
            end
        end
    end

    assign io_sw.step_out   = r_step;
    assign io_sw.step_valid = r_valid;
    assign io_sw.busy       = r_busy;
    assign io_sw.done       = r_done;
`ifdef TRI_SWEEP_BIDIR_EN
    assign io_sw.sweep_dir  = r_dir;
`else
    assign io_sw.sweep_dir  = 1'b0;
`endif
endmodule

// File: tb/tb_tri_sweep_ctrl.sv
// tb_tri_sweep_ctrl: directed checks of tri_sweep_ctrl sweeps, saturation, abort, reset and ignored requests.
module tb_tri_sweep_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   tests_run = 0;
    int   tests_failed = 0;
    logic [31:0] cap_vals[16];
    int          cap_t[16];
    logic        cap_dir[16];
    int          cap_n, cap_done_at;
    bit          cap_busy_bad;

    tri_sweep_if #(.STEP_W(32), .DWELL_W(24)) sw ();
    tri_sweep_ctrl #(.STEP_W(32), .DWELL_W(24)) dut (.clk(clk), .rst_n(rst_n), .io_sw(sw));

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one sweep and records every step_valid pulse; t counts cycles after the start edge.
    task automatic do_sweep(input logic [31:0] s, input logic [31:0] p, input logic [31:0] i,
                            input logic [23:0] d, input int poke_t);
        cap_n = 0;
        cap_done_at = 0;
        cap_busy_bad = 0;
        sw.cfg_step_start = s;
        sw.cfg_step_stop = p;
        sw.cfg_step_inc = i;
        sw.cfg_dwell = d;
        sw.start = 1'b1;
        tick();
        sw.start = 1'b0;
        for (int t = 1; t <= 300; t++) begin
            if (sw.step_valid && cap_n < 16) begin
                cap_vals[cap_n] = sw.step_out;
                cap_t[cap_n] = t;
                cap_dir[cap_n] = sw.sweep_dir;
                cap_n++;
            end
            if (sw.done) begin
                cap_done_at = t;
                if (sw.busy) cap_busy_bad = 1;
                break;
            end
            if (!sw.busy) cap_busy_bad = 1;
            sw.start = (t == poke_t);
            if (t == poke_t) begin
                sw.cfg_step_start = 32'd7;
                sw.cfg_step_stop = 32'd9000;
                sw.cfg_step_inc = 32'd1;
                sw.cfg_dwell = 24'd0;
            end
            tick();
        end
        sw.start = 1'b0;
    endtask

    task automatic test_reset();
        sw.start = 1'b0;
        sw.abort = 1'b0;
        sw.cfg_step_start = '0;
        sw.cfg_step_stop = '0;
        sw.cfg_step_inc = '0;
        sw.cfg_dwell = '0;
        rst_n = 1'b0;
        #2;
        tests_run++;
        if ({sw.step_out, sw.step_valid, sw.busy, sw.done, sw.sweep_dir} !== 36'd0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got step=%0h v=%b b=%b d=%b dir=%b, want all 0",
                     sw.step_out, sw.step_valid, sw.busy, sw.done, sw.sweep_dir);
        end
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (2) tick();
        tests_run++;
        if (sw.busy !== 1'b0 || sw.step_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_idle: got busy=%b valid=%b, want 0 0", sw.busy, sw.step_valid);
        end
    endtask

    task automatic test_basic();
        do_sweep(32'd100, 32'd400, 32'd100, 24'd3, 0);
        tests_run++;
        if (cap_n !== 4) begin
            tests_failed++;
            $display("FAIL basic_count: got %0d pulses, want 4", cap_n);
        end
        for (int k = 0; k < 4; k++) begin
            tests_run++;
            if (cap_vals[k] !== 32'(100 * (k + 1)) || cap_t[k] !== 1 + 4 * k) begin
                tests_failed++;
                $display("FAIL basic_stage%0d: got %0d at t=%0d, want %0d at t=%0d",
                         k, cap_vals[k], cap_t[k], 100 * (k + 1), 1 + 4 * k);
            end
        end
        tests_run++;
        if (cap_done_at !== 17 || cap_busy_bad) begin
            tests_failed++;
            $display("FAIL basic_done: got done at t=%0d busy_bad=%b, want t=17 busy_bad=0",
                     cap_done_at, cap_busy_bad);
        end
    endtask

    task automatic test_back_to_back();
        tick();
        do_sweep(32'd0, 32'd250, 32'd100, 24'd0, 0);
        tests_run++;
        if (cap_n !== 4 || cap_vals[0] !== 32'd0 || cap_vals[1] !== 32'd100 ||
            cap_vals[2] !== 32'd200 || cap_vals[3] !== 32'd250) begin
            tests_failed++;
            $display("FAIL saturate_seq: got n=%0d %0d %0d %0d %0d, want 4: 0 100 200 250",
                     cap_n, cap_vals[0], cap_vals[1], cap_vals[2], cap_vals[3]);
        end
        tests_run++;
        if (cap_done_at !== 5) begin
            tests_failed++;
            $display("FAIL saturate_done: got t=%0d, want 5", cap_done_at);
        end
    endtask

    task automatic test_overflow();
        tick();
        do_sweep(32'hFFFFFF00, 32'hFFFFFFFF, 32'h200, 24'd1, 0);
        tests_run++;
        if (cap_n !== 2 || cap_vals[0] !== 32'hFFFFFF00 || cap_vals[1] !== 32'hFFFFFFFF) begin
            tests_failed++;
            $display("FAIL overflow_seq: got n=%0d %h %h, want 2: ffffff00 ffffffff",
                     cap_n, cap_vals[0], cap_vals[1]);
        end
        tests_run++;
        if (cap_done_at !== 5) begin
            tests_failed++;
            $display("FAIL overflow_done: got t=%0d, want 5", cap_done_at);
        end
    endtask

`ifdef TRI_SWEEP_BIDIR_EN
    task automatic test_bidir();
        logic [31:0] exp_v[5];
        logic        exp_d[5];
        exp_v = '{32'd100, 32'd200, 32'd300, 32'd200, 32'd100};
        exp_d = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        tick();
        do_sweep(32'd100, 32'd300, 32'd100, 24'd0, 0);
        tests_run++;
        if (cap_n !== 5) begin
            tests_failed++;
            $display("FAIL bidir_count: got %0d pulses, want 5", cap_n);
        end
        for (int k = 0; k < 5; k++) begin
            tests_run++;
            if (cap_vals[k] !== exp_v[k] || cap_dir[k] !== exp_d[k] || cap_t[k] !== k + 1) begin
                tests_failed++;
                $display("FAIL bidir_stage%0d: got %0d dir=%b t=%0d, want %0d dir=%b t=%0d",
                         k, cap_vals[k], cap_dir[k], cap_t[k], exp_v[k], exp_d[k], k + 1);
            end
        end
        tests_run++;
        if (cap_done_at !== 6 || sw.sweep_dir !== 1'b0) begin
            tests_failed++;
            $display("FAIL bidir_done: got t=%0d dir=%b, want t=6 dir=0", cap_done_at, sw.sweep_dir);
        end
    endtask
`endif

    task automatic test_degenerate();
        tick();
        do_sweep(32'd10, 32'd50, 32'd0, 24'd2, 0);
        tests_run++;
        if (cap_n !== 1 || cap_vals[0] !== 32'd10 || cap_done_at !== 4) begin
            tests_failed++;
            $display("FAIL inc_zero: got n=%0d val=%0d done t=%0d, want 1 10 4",
                     cap_n, cap_vals[0], cap_done_at);
        end
        tick();
        do_sweep(32'd500, 32'd100, 32'd50, 24'd1, 0);
        tests_run++;
        if (cap_n !== 1 || cap_vals[0] !== 32'd500 || cap_done_at !== 3) begin
            tests_failed++;
            $display("FAIL start_ge_stop: got n=%0d val=%0d done t=%0d, want 1 500 3",
                     cap_n, cap_vals[0], cap_done_at);
        end
    endtask

    task automatic test_ignored();
        tick();
        do_sweep(32'd100, 32'd100, 32'd5, 24'd5, 3);
        tests_run++;
        if (cap_n !== 1 || cap_vals[0] !== 32'd100 || cap_done_at !== 7) begin
            tests_failed++;
            $display("FAIL start_while_busy: got n=%0d val=%0d done t=%0d, want 1 100 7",
                     cap_n, cap_vals[0], cap_done_at);
        end
        tick();
        sw.cfg_step_start = 32'd33;
        sw.start = 1'b1;
        sw.abort = 1'b1;
        tick();
        sw.start = 1'b0;
        sw.abort = 1'b0;
        tick();
        tests_run++;
        if (sw.busy !== 1'b0 || sw.step_valid !== 1'b0 || sw.step_out !== 32'd100) begin
            tests_failed++;
            $display("FAIL start_abort_idle: got busy=%b valid=%b step=%0d, want 0 0 100",
                     sw.busy, sw.step_valid, sw.step_out);
        end
    endtask

    task automatic test_abort();
        int dones = 0;
        sw.cfg_step_start = 32'd100;
        sw.cfg_step_stop = 32'd400;
        sw.cfg_step_inc = 32'd100;
        sw.cfg_dwell = 24'd3;
        sw.start = 1'b1;
        tick();
        sw.start = 1'b0;
        repeat (4) tick();
        tests_run++;
        if (sw.step_out !== 32'd200 || sw.busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL abort_pre: got step=%0d busy=%b, want 200 1", sw.step_out, sw.busy);
        end
        sw.abort = 1'b1;
        tick();
        sw.abort = 1'b0;
        tests_run++;
        if (sw.step_out !== 32'd0 || sw.step_valid !== 1'b1 || sw.busy !== 1'b0 || sw.done !== 1'b0) begin
            tests_failed++;
            $display("FAIL abort_next: got step=%0d v=%b b=%b d=%b, want 0 1 0 0",
                     sw.step_out, sw.step_valid, sw.busy, sw.done);
        end
        for (int k = 0; k < 20; k++) begin
            tick();
            if (sw.done || sw.busy) dones++;
        end
        tests_run++;
        if (dones !== 0) begin
            tests_failed++;
            $display("FAIL abort_quiet: got %0d busy/done cycles after abort, want 0", dones);
        end
        sw.start = 1'b1;
        tick();
        sw.start = 1'b0;
        repeat (2) tick();
        #1;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({sw.step_out, sw.step_valid, sw.busy, sw.done, sw.sweep_dir} !== 36'd0) begin
            tests_failed++;
            $display("FAIL async_reset: got step=%0d v=%b b=%b d=%b dir=%b, want all 0",
                     sw.step_out, sw.step_valid, sw.busy, sw.done, sw.sweep_dir);
        end
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
`ifdef TRI_SWEEP_BIDIR_EN
        test_bidir();
`else
        test_basic();
        test_back_to_back();
        test_overflow();
`endif
        test_degenerate();
        test_ignored();
        test_abort();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation still running at %0t, want finished", $time);
        $fatal(1, "timeout");
    end
endmodule
